// File: rtl/vedic_mac_accumulator.sv
// Accumulates N_TERMS unsigned 8-bit products from the Vedic multiplier into a
// wide register, then holds the dot-product result until it is cleared.
module vedic_mac_accumulator #(
    parameter int ACC_W   = 16,
    parameter int CNT_W   = 4,
    parameter int N_TERMS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    input  logic             clear,
    input  logic             byte_sel,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       out_byte,
    output logic [CNT_W-1:0] term_cnt,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

    state_t           state;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_next;
    logic [15:0]      acc_ext;

    // The extra top bit of sum_ext is the carry-out that feeds the sticky overflow.
    assign sum_ext  = {1'b0, acc_out} + {{(ACC_W - 7){1'b0}}, prod_in};
    assign cnt_next = term_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            state    <= IDLE;
            acc_out  <= '0;
            term_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (ena) begin
            if (clear) begin
                state    <= IDLE;
                acc_out  <= '0;
                term_cnt <= '0;
                busy     <= 1'b0;
                done     <= 1'b0;
                overflow <= 1'b0;
            end else if (prod_valid) begin
                case (state)
                    IDLE: begin
                        acc_out  <= ACC_W'(prod_in);
                        term_cnt <= CNT_W'(1);
                        overflow <= 1'b0;
                        if (N_TERMS == 1) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ACCUM;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                    ACCUM: begin
                        acc_out  <= sum_ext[ACC_W-1:0];
                        term_cnt <= cnt_next;
                        overflow <= overflow | sum_ext[ACC_W];
                        if (cnt_next == LAST_CNT) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: ; // DONE ignores further terms until cleared
                endcase
            end
        end
    end

    // Normalise the accumulator to 16 bits so the high byte zero-fills on narrow builds.
    generate
        if (ACC_W >= 16) begin : g_wide
            assign acc_ext = acc_out[15:0];
        end else begin : g_narrow
            assign acc_ext = {{(16 - ACC_W){1'b0}}, acc_out};
        end
    endgenerate

    assign out_byte = byte_sel ? acc_ext[15:8] : acc_ext[7:0];

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// Directed bench for vedic_mac_accumulator: a 16-bit/4-term main instance, an
// 8-bit/2-term overflow instance and a 1-term instance.
module tb_vedic_mac_accumulator;

    logic clk, rst_n, ena, clear, byte_sel;

    logic [7:0]  m_prod, o_prod, s_prod;
    logic        m_valid, o_valid, s_valid;

    logic [15:0] m_acc;
    logic [7:0]  m_byte;
    logic [3:0]  m_cnt;
    logic        m_busy, m_done, m_ovf;

    logic [7:0]  o_acc;
    logic [7:0]  o_byte;
    logic [3:0]  o_cnt;
    logic        o_busy, o_done, o_ovf;

    logic [15:0] s_acc;
    logic [7:0]  s_byte;
    logic [3:0]  s_cnt;
    logic        s_busy, s_done, s_ovf;

    int checks   = 0;
    int failures = 0;

    vedic_mac_accumulator #(.ACC_W(16), .CNT_W(4), .N_TERMS(4)) u_main (
        .clk(clk), .rst_n(rst_n), .ena(ena), .prod_in(m_prod), .prod_valid(m_valid),
        .clear(clear), .byte_sel(byte_sel), .acc_out(m_acc), .out_byte(m_byte),
        .term_cnt(m_cnt), .busy(m_busy), .done(m_done), .overflow(m_ovf)
    );

    vedic_mac_accumulator #(.ACC_W(8), .CNT_W(4), .N_TERMS(2)) u_ovf (
        .clk(clk), .rst_n(rst_n), .ena(ena), .prod_in(o_prod), .prod_valid(o_valid),
        .clear(clear), .byte_sel(byte_sel), .acc_out(o_acc), .out_byte(o_byte),
        .term_cnt(o_cnt), .busy(o_busy), .done(o_done), .overflow(o_ovf)
    );

    vedic_mac_accumulator #(.ACC_W(16), .CNT_W(4), .N_TERMS(1)) u_one (
        .clk(clk), .rst_n(rst_n), .ena(ena), .prod_in(s_prod), .prod_valid(s_valid),
        .clear(clear), .byte_sel(byte_sel), .acc_out(s_acc), .out_byte(s_byte),
        .term_cnt(s_cnt), .busy(s_busy), .done(s_done), .overflow(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_main(input logic [7:0] p);
        m_valid = 1'b1;
        m_prod  = p;
        step();
        m_valid = 1'b0;
        m_prod  = 8'd0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (m_acc !== 16'd0) begin failures++; $display("FAIL reset_acc: got %0d expected 0", m_acc); end
        checks++; if (m_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", m_cnt); end
        checks++; if ({m_busy, m_done, m_ovf} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {m_busy, m_done, m_ovf}); end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_normal();
        send_main(8'd6);
        checks++; if (m_acc !== 16'd6 || m_busy !== 1'b1) begin failures++; $display("FAIL normal_first: got acc=%0d busy=%b expected acc=6 busy=1", m_acc, m_busy); end
        send_main(8'd20);
        send_main(8'd225);
        checks++; if (m_acc !== 16'd251 || m_cnt !== 4'd3 || m_done !== 1'b0) begin failures++; $display("FAIL normal_third: got acc=%0d cnt=%0d done=%b expected 251/3/0", m_acc, m_cnt, m_done); end
        send_main(8'd0);
        checks++; if (m_acc !== 16'h00FB) begin failures++; $display("FAIL normal_acc: got %h expected 00fb", m_acc); end
        checks++; if (m_cnt !== 4'd4) begin failures++; $display("FAIL normal_cnt: got %0d expected 4", m_cnt); end
        checks++; if ({m_busy, m_done, m_ovf} !== 3'b010) begin failures++; $display("FAIL normal_flags: got %b expected 010", {m_busy, m_done, m_ovf}); end
        byte_sel = 1'b0;
        #1;
        checks++; if (m_byte !== 8'hFB) begin failures++; $display("FAIL normal_byte_lo: got %h expected fb", m_byte); end
        byte_sel = 1'b1;
        #1;
        checks++; if (m_byte !== 8'h00) begin failures++; $display("FAIL normal_byte_hi: got %h expected 00", m_byte); end
        byte_sel = 1'b0;
    endtask

    task automatic test_done_and_clear();
        send_main(8'd100);
        checks++; if (m_acc !== 16'd251 || m_cnt !== 4'd4 || m_done !== 1'b1) begin failures++; $display("FAIL done_ignores: got acc=%0d cnt=%0d done=%b expected 251/4/1", m_acc, m_cnt, m_done); end
        clear   = 1'b1;
        m_valid = 1'b1;
        m_prod  = 8'd50;
        step();
        clear   = 1'b0;
        m_valid = 1'b0;
        checks++; if (m_acc !== 16'd0 || m_cnt !== 4'd0 || m_done !== 1'b0 || m_busy !== 1'b0) begin failures++; $display("FAIL clear_priority: got acc=%0d cnt=%0d done=%b busy=%b expected 0/0/0/0", m_acc, m_cnt, m_done, m_busy); end
        send_main(8'd50);
        checks++; if (m_acc !== 16'd50 || m_cnt !== 4'd1 || m_busy !== 1'b1) begin failures++; $display("FAIL restart: got acc=%0d cnt=%0d busy=%b expected 50/1/1", m_acc, m_cnt, m_busy); end
        do_clear();
    endtask

    task automatic test_gapped_stall();
        send_main(8'd6);
        step(); step();
        send_main(8'd20);
        step(); step();
        ena     = 1'b0;
        m_valid = 1'b1;
        m_prod  = 8'd99;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (m_acc !== 16'd26 || m_cnt !== 4'd2 || m_busy !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d]: got acc=%0d cnt=%0d busy=%b expected 26/2/1", i, m_acc, m_cnt, m_busy); end
        end
        ena     = 1'b1;
        m_valid = 1'b0;
        m_prod  = 8'd0;
        step();
        send_main(8'd225);
        step(); step();
        send_main(8'd0);
        checks++; if (m_acc !== 16'h00FB || m_cnt !== 4'd4 || m_done !== 1'b1) begin failures++; $display("FAIL gapped_final: got acc=%h cnt=%0d done=%b expected 00fb/4/1", m_acc, m_cnt, m_done); end
        do_clear();
    endtask

    task automatic test_overflow();
        o_valid = 1'b1;
        o_prod  = 8'd225;
        step();
        checks++; if (o_acc !== 8'd225 || o_ovf !== 1'b0 || o_done !== 1'b0) begin failures++; $display("FAIL ovf_first: got acc=%0d ovf=%b done=%b expected 225/0/0", o_acc, o_ovf, o_done); end
        step();
        o_valid = 1'b0;
        checks++; if (o_acc !== 8'd194 || o_ovf !== 1'b1 || o_done !== 1'b1) begin failures++; $display("FAIL ovf_wrap: got acc=%0d ovf=%b done=%b expected 194/1/1", o_acc, o_ovf, o_done); end
        byte_sel = 1'b1;
        #1;
        checks++; if (o_byte !== 8'h00) begin failures++; $display("FAIL ovf_byte_zero_fill: got %h expected 00", o_byte); end
        byte_sel = 1'b0;
        #1;
        checks++; if (o_byte !== 8'd194) begin failures++; $display("FAIL ovf_byte_lo: got %0d expected 194", o_byte); end
        do_clear();
        checks++; if (o_ovf !== 1'b0 || o_acc !== 8'd0) begin failures++; $display("FAIL ovf_clear: got ovf=%b acc=%0d expected 0/0", o_ovf, o_acc); end
    endtask

    task automatic test_async_reset();
        send_main(8'd6);
        send_main(8'd20);
        checks++; if (m_acc !== 16'd26) begin failures++; $display("FAIL async_pre: got %0d expected 26", m_acc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m_acc !== 16'd0 || m_cnt !== 4'd0 || {m_busy, m_done, m_ovf} !== 3'b000) begin failures++; $display("FAIL async_immediate: got acc=%0d cnt=%0d flags=%b expected 0/0/000", m_acc, m_cnt, {m_busy, m_done, m_ovf}); end
        #3 rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send_main(8'd15);
        checks++; if (m_acc !== 16'd60 || m_done !== 1'b1 || m_cnt !== 4'd4) begin failures++; $display("FAIL async_after: got acc=%0d done=%b cnt=%0d expected 60/1/4", m_acc, m_done, m_cnt); end
        do_clear();
    endtask

    task automatic test_single_term();
        logic busy_seen;
        busy_seen = s_busy;
        s_valid = 1'b1;
        s_prod  = 8'd225;
        step();
        busy_seen = busy_seen | s_busy;
        checks++; if (s_acc !== 16'd225 || s_done !== 1'b1 || s_cnt !== 4'd1) begin failures++; $display("FAIL single_done: got acc=%0d done=%b cnt=%0d expected 225/1/1", s_acc, s_done, s_cnt); end
        s_prod = 8'd7;
        step();
        s_valid = 1'b0;
        busy_seen = busy_seen | s_busy;
        checks++; if (s_acc !== 16'd225) begin failures++; $display("FAIL single_hold: got %0d expected 225", s_acc); end
        checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL single_busy: got %b expected 0", busy_seen); end
        do_clear();
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        clear    = 1'b0;
        byte_sel = 1'b0;
        m_prod = 8'd0; o_prod = 8'd0; s_prod = 8'd0;
        m_valid = 1'b0; o_valid = 1'b0; s_valid = 1'b0;

        test_reset();
        test_normal();
        test_done_and_clear();
        test_gapped_stall();
        test_overflow();
        test_async_reset();
        test_single_term();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vedic_mac_accumulator.md
Name: vedic_mac_accumulator

Overview:
Downstream stage of the 4x4 Vedic multiplier inside the Tiny Tapeout user design. It consumes the 8-bit product (uo_out-equivalent) with a valid strobe and accumulates N_TERMS products into a wide register, producing a dot-product result. A small FSM counts terms, flags completion, and holds the result until cleared. A byte-select mux exposes the result through an 8-bit pin bank.

Parameters:
ACC_W, 16, accumulator width in bits; must be >= 8.
CNT_W, 4, term counter width in bits.
N_TERMS, 4, products per accumulation; range 1 .. 2**CNT_W-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
ena  input  1  TT enable; when low, all state holds.
prod_in  input  8  product from the 4x4 multiplier, unsigned.
prod_valid  input  1  prod_in is a term to accumulate this cycle.
clear  input  1  synchronous clear back to IDLE.
byte_sel  input  1  0 selects acc[7:0], 1 selects acc[15:8] on out_byte.
acc_out  output  ACC_W  accumulator register.
out_byte  output  8  combinational byte mux of acc_out.
term_cnt  output  CNT_W  number of terms accumulated so far.
busy  output  1  high in ACCUM.
done  output  1  high in DONE.
overflow  output  1  sticky carry-out of the accumulator.

Behaviour:
- Reset is asynchronous, active-low, and applies to clk/rst_n: state=IDLE; acc_out, term_cnt, busy, done and overflow are all 0.
- FSM states are IDLE, ACCUM and DONE. busy and done are registered decodes of the state.
- ena=0: no register changes, regardless of clear or prod_valid.
- Priority with ena=1 is clear > prod_valid.
- clear, in any state: next cycle state=IDLE, acc=0, cnt=0, overflow=0. A prod_valid in the same cycle is dropped.
- IDLE with prod_valid: acc=prod_in (zero-extended), cnt=1, overflow=0.
  - Next state is DONE if N_TERMS==1, otherwise ACCUM.
- ACCUM with prod_valid: acc = acc + prod_in, computed modulo 2**ACC_W; cnt = cnt+1.
  - overflow |= carry-out of that addition.
  - When the new cnt equals N_TERMS, next state is DONE.
- ACCUM without prod_valid: hold.
- DONE: acc, cnt and overflow hold. prod_valid is ignored, so no restart without clear.
- Latency: acc_out and term_cnt reflect a term one cycle after the edge that sampled prod_valid. done rises on the same edge that absorbs term N_TERMS.
- Gaps between valid cycles are allowed; back-to-back valid accumulates one term per cycle.
- out_byte:
  - byte_sel=0 gives acc[7:0].
  - byte_sel=1 gives acc[15:8], with zero-fill above ACC_W-1 if ACC_W<16.
- Reset asserted mid-accumulation: immediate return to the reset values; no partial result is retained.

Test Plan:
- Normal accumulation (N_TERMS=4, ACC_W=16): valid products 6, 20, 225, 0, i.e. 3*2, 5*4, 15*15, 9*0, on consecutive cycles -> acc_out=0x00FB (251), term_cnt=4, done=1 one cycle after the 4th valid, overflow=0, busy=0. Then byte_sel=0 -> out_byte=0xFB; byte_sel=1 -> out_byte=0x00.
- Gapped valids plus ena stall: same four products with two idle cycles between each, and ena=0 for 3 cycles mid-run -> identical final 0x00FB and term_cnt=4. Values hold during the stall even if prod_valid=1.
- Extra terms and clear:
  - In DONE, pulse prod_valid with prod_in=100 -> acc stays 251.
  - Assert clear with prod_valid=1, prod_in=50 -> next cycle IDLE, acc=0, cnt=0, done=0.
  - A subsequent valid 50 -> acc=50, cnt=1, busy=1.
- Overflow (ACC_W=8, N_TERMS=2): products 225 then 225 -> acc_out=194 (450 mod 256), overflow=1, done=1. After clear -> overflow=0.
- Async reset mid-run: after terms 6 and 20 (acc=26), drop rst_n between clock edges -> all outputs 0 immediately, without waiting for an edge. Release, then send 4 terms of 15 -> acc=60, done=1.
- Single-term config (N_TERMS=1): one valid with prod_in=225 -> acc=225 and done=1 on the next edge; busy never asserts.
